// File: rtl/bounce_pkg.sv
// Shared types and default constants for the bouncing-LED step scheduler.
// Positions and velocities are signed q8.24 words.
package bounce_pkg;

  typedef logic signed [31:0] q824_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GRAV    = 3'd1;
  localparam logic [2:0] ST_MOVE    = 3'd2;
  localparam logic [2:0] ST_FLR_MUL = 3'd3;
  localparam logic [2:0] ST_FLR_NEG = 3'd4;
  localparam logic [2:0] ST_CEIL    = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  typedef enum logic [1:0] {
    ALU_ADD     = 2'd0,
    ALU_SUB     = 2'd1,
    ALU_NEG     = 2'd2,
    ALU_SAT_ADD = 2'd3
  } alu_op_e;

  localparam q824_t DEF_INIT_POS      = 32'sd1000;
  localparam q824_t DEF_INIT_VEL      = 32'sh03000000;
  localparam q824_t DEF_DV_LOW        = 32'sd3355;
  localparam q824_t DEF_DV_HIGH       = 32'sd3356;
  localparam q824_t DEF_KICK_VEL      = 32'sh03000000;
  localparam q824_t DEF_FLOOR_RESTORE = 32'sh00000100;
  localparam int    DEF_VSHIFT        = 16;
  localparam int    DEF_CEIL_INT      = 10;

endpackage

// File: rtl/q824_alu.sv
// Single shared 32-bit adder: ADD, SUB, NEG (0 - b) and a signed saturating ADD.
module q824_alu
  import bounce_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic        sub;
  logic        ovf;
  logic [31:0] lhs;
  logic [31:0] rhs;
  logic [31:0] sum;

  always_comb begin
    sub = (op == ALU_SUB) || (op == ALU_NEG);
    lhs = (op == ALU_NEG) ? 32'd0 : a;
    rhs = sub ? ~b : b;
    sum = lhs + rhs + {31'd0, sub};
    // Overflow only matters for the saturating form; operands share a sign, result flips.
    ovf = (a[31] == b[31]) && (sum[31] != a[31]);
    y   = sum;
    if ((op == ALU_SAT_ADD) && ovf) begin
      y = a[31] ? 32'h80000000 : 32'h7FFFFFFF;
    end
  end

endmodule

// File: rtl/bounce_step_scheduler.sv
// Per-tick physics sequencer for the bouncing LED: gravity, integration, floor and
// ceiling bounce through one shared adder, plus Kick/Load arbitration and overrun.
module bounce_step_scheduler
  import bounce_pkg::*;
#(
  parameter q824_t INIT_POS      = DEF_INIT_POS,
  parameter q824_t INIT_VEL      = DEF_INIT_VEL,
  parameter q824_t DV_LOW        = DEF_DV_LOW,
  parameter q824_t DV_HIGH       = DEF_DV_HIGH,
  parameter q824_t KICK_VEL      = DEF_KICK_VEL,
  parameter int    VSHIFT        = DEF_VSHIFT,
  parameter int    CEIL_INT      = DEF_CEIL_INT,
  parameter q824_t FLOOR_RESTORE = DEF_FLOOR_RESTORE
) (
  input  logic        CLOCK_50,
  input  logic        Reset_n,
  input  logic        Tick,
  input  logic        Kick,
  input  logic        Load,
  input  logic [31:0] LoadPos,
  input  logic [31:0] LoadVel,
  output logic [31:0] Position,
  output logic [31:0] Velocity,
  output logic        Ready,
  output logic        StepDone,
  output logic        Bounce,
  output logic        Overrun
);

  localparam logic signed [7:0] CEIL_I8    = 8'(CEIL_INT);
  localparam logic signed [7:0] CEIL_M1_I8 = 8'(CEIL_INT - 1);

  logic [2:0] state_reg, state_next;
  q824_t      pos_reg, pos_next;
  q824_t      vel_reg, vel_next;
  q824_t      tmp_reg, tmp_next;
  logic       dv_sel_reg, dv_sel_next;
  logic       tick_pend_reg, tick_pend_next;
  logic       kick_pend_reg, kick_pend_next;
  logic       bnc_reg, bnc_next;
  logic       step_done_reg, step_done_next;
  logic       bounce_reg, bounce_next;
  logic       overrun_reg, overrun_next;

  logic        tick_take;
  logic        kick_take;
  logic [1:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  q824_t       vel_q;

  q824_alu u_alu (
    .op (alu_op),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  assign Ready = (state_reg == ST_IDLE) && !tick_pend_reg && !kick_pend_reg;
  assign vel_q = vel_reg >>> 2;

  always_comb begin
    state_next     = state_reg;
    pos_next       = pos_reg;
    vel_next       = vel_reg;
    tmp_next       = tmp_reg;
    dv_sel_next    = dv_sel_reg;
    bnc_next       = bnc_reg;
    step_done_next = 1'b0;
    bounce_next    = 1'b0;
    tick_take      = 1'b0;
    kick_take      = 1'b0;
    alu_op         = ALU_ADD;
    alu_a          = vel_reg;
    alu_b          = KICK_VEL;

    case (state_reg)
      ST_IDLE: begin
        if (Load && Ready) begin
          pos_next = LoadPos;
          vel_next = LoadVel;
        end else if (kick_pend_reg) begin
          kick_take = 1'b1;
          alu_op    = ALU_SAT_ADD;
          vel_next  = (vel_reg <= 32'sd0) ? KICK_VEL : alu_y;
        end else if (tick_pend_reg) begin
          tick_take  = 1'b1;
          state_next = ST_GRAV;
        end
      end
      ST_GRAV: begin
        alu_op      = ALU_SUB;
        alu_b       = dv_sel_reg ? DV_HIGH : DV_LOW;
        vel_next    = alu_y;
        dv_sel_next = !dv_sel_reg;
        state_next  = ST_MOVE;
      end
      ST_MOVE: begin
        alu_a      = pos_reg;
        alu_b      = vel_reg >>> VSHIFT;
        pos_next   = alu_y;
        state_next = ST_FLR_MUL;
      end
      ST_FLR_MUL: begin
        // 0.75 * velocity as (v/4) + 2*(v/4)
        alu_a = vel_q;
        alu_b = vel_q <<< 1;
        if ((pos_reg <= 32'sd0) && (vel_reg < 32'sd0)) begin
          bnc_next = 1'b1;
          tmp_next = alu_y;
        end else if (pos_reg < 32'sd0) begin
          pos_next = 32'sd0;
        end
        state_next = ST_FLR_NEG;
      end
      ST_FLR_NEG: begin
        alu_op = ALU_NEG;
        alu_b  = tmp_reg;
        if (bnc_reg) begin
          vel_next = alu_y;
          pos_next = FLOOR_RESTORE;
        end
        state_next = ST_CEIL;
      end
      ST_CEIL: begin
        alu_op = ALU_NEG;
        alu_b  = vel_reg;
        if (($signed(pos_reg[31:24]) >= CEIL_I8) && (vel_reg > 32'sd0)) begin
          vel_next        = alu_y;
          pos_next[31:24] = CEIL_M1_I8;
        end
        // Registered pulses land together with the final committed values.
        step_done_next = 1'b1;
        bounce_next    = bnc_reg;
        state_next     = ST_DONE;
      end
      ST_DONE: begin
        bnc_next   = 1'b0;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    tick_pend_next = tick_pend_reg ? !tick_take : Tick;
    overrun_next   = overrun_reg || (Tick && tick_pend_reg);
    kick_pend_next = Kick || (kick_pend_reg && !kick_take);
  end

  always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg     <= ST_IDLE;
      pos_reg       <= INIT_POS;
      vel_reg       <= INIT_VEL;
      tmp_reg       <= '0;
      dv_sel_reg    <= 1'b1;
      tick_pend_reg <= 1'b0;
      kick_pend_reg <= 1'b0;
      bnc_reg       <= 1'b0;
      step_done_reg <= 1'b0;
      bounce_reg    <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pos_reg       <= pos_next;
      vel_reg       <= vel_next;
      tmp_reg       <= tmp_next;
      dv_sel_reg    <= dv_sel_next;
      tick_pend_reg <= tick_pend_next;
      kick_pend_reg <= kick_pend_next;
      bnc_reg       <= bnc_next;
      step_done_reg <= step_done_next;
      bounce_reg    <= bounce_next;
      overrun_reg   <= overrun_next;
    end
  end

  assign Position = pos_reg;
  assign Velocity = vel_reg;
  assign StepDone = step_done_reg;
  assign Bounce   = bounce_reg;
  assign Overrun  = overrun_reg;

endmodule

// File: doc/bounce_step_scheduler.md
Name: bounce_step_scheduler

Overview:
Sequences the per-time-step physics update of the bouncing-LED model: gravity, position integration, floor bounce and ceiling bounce. One shared 32-bit adder runs one fixed-latency operation per FSM state. The block also arbitrates asynchronous Kick and Load configuration requests against Tick (time-step) requests, and detects tick overrun. It sits between Timer_20_48us/EdgeDetector and the LEDR/HEX display logic, and replaces the ad-hoc update in the top level.

Parameters:
INIT_POS, 32'sd1000, Position value on reset (signed q8.24)
INIT_VEL, 32'sh03000000, Velocity value on reset
DV_LOW, 32'sd3355, gravity decrement on odd steps
DV_HIGH, 32'sd3356, gravity decrement on even steps (first step after reset)
KICK_VEL, 32'sh03000000, Kick velocity addend
VSHIFT, 16, arithmetic right shift applied to velocity when integrating position
CEIL_INT, 10, ceiling as integer part (Position[31:24])
FLOOR_RESTORE, 32'sh00000100, Position written on floor bounce

Ports:
CLOCK_50  in  1  sole clock, rising edge
Reset_n  in  1  asynchronous, active-low reset
Tick  in  1  one-cycle time-step pulse
Kick  in  1  one-cycle velocity-kick pulse
Load  in  1  one-cycle config strobe; accepted only when Ready=1
LoadPos  in  32  signed q8.24 position to load
LoadVel  in  32  signed q8.24 velocity to load
Position  out  32  signed q8.24 current position
Velocity  out  32  signed q8.24 current velocity
Ready  out  1  high in IDLE with no pending request
StepDone  out  1  one-cycle pulse when a step commits
Bounce  out  1  one-cycle pulse with StepDone if a floor bounce occurred
Overrun  out  1  sticky; set when a Tick is dropped

Behaviour:
- Reset (async, Reset_n=0): Position=INIT_POS, Velocity=INIT_VEL, state IDLE, dv_sel=HIGH, pend flags=0, StepDone=Bounce=Overrun=0. Reset mid-step aborts the step with no partial commit.
- States: IDLE, GRAV, MOVE, FLR_MUL, FLR_NEG, CEIL, DONE. Each non-IDLE state lasts exactly 1 cycle.
- Request latching (every cycle):
  - Tick sets tick_pend.
  - If Tick arrives while tick_pend=1, or while tick_pend=1 and a step is in progress, the Tick is dropped and Overrun is set.
  - Kick sets kick_pend.
- IDLE priority, highest first:
  - Load (applied the same cycle): Position<=LoadPos, Velocity<=LoadVel.
  - kick_pend: 1 cycle. If Velocity<=0 then Velocity<=KICK_VEL, else Velocity<=Velocity+KICK_VEL, saturating at 32'sh7FFFFFFF. Clear kick_pend.
  - tick_pend: go to GRAV and clear tick_pend.
  - Load with Ready=0 is ignored.
- GRAV: Velocity<=Velocity-(dv_sel?DV_HIGH:DV_LOW); toggle dv_sel.
- MOVE: Position<=Position+(Velocity>>>VSHIFT), using the post-GRAV velocity.
- FLR_MUL:
  - If Position<=0 and Velocity<0: set bnc, t=Velocity>>>2, tmp<=t+(t<<<1).
  - Else if Position<0: Position<=0.
- FLR_NEG: if bnc, Velocity<=-tmp and Position<=FLOOR_RESTORE.
- CEIL: if signed Position[31:24]>=CEIL_INT and Velocity>0, Velocity<=-Velocity and Position[31:24]<=CEIL_INT-1 (low 24 bits kept).
- DONE: StepDone=1, Bounce=bnc; clear bnc; return to IDLE.
- Latency: a Tick sampled in IDLE produces StepDone exactly 6 cycles later. A pending Kick or Load delays the step by 1 cycle each.
- Kick arriving mid-step stays pending and is applied in IDLE after DONE.
- All arithmetic is 32-bit signed two's complement. Only the Kick path saturates; all other overflow wraps.
- Outputs are registered; Ready is combinational from state and pend flags.

Decomposition:
- Package bounce_pkg: state enum; q8.24 typedef (signed [31:0]); default constants (DV_LOW/HIGH, KICK_VEL, FLOOR_RESTORE, CEIL_INT).
- Sub-module q824_alu: single shared adder with an operand/opcode mux (ADD, SUB, NEG, SAT_ADD), purely combinational. Remaining FSM and registers stay in bounce_step_scheduler.

Test Plan:
- Reset, then Tick -> after 6 cycles StepDone=1, Velocity=32'h02FFF2E4, Position=1767, Bounce=0.
- Load p=0, v=32'hFF000000, then Tick -> Velocity=32'h00C009D5, Position=32'h00000100, Bounce=1 with StepDone.
- Load p=32'h0A000000, v=32'h01000000, then Tick -> Velocity=32'hFF000D1C, Position=32'h090000FF.
- Kicks:
  - After reset, Kick -> Velocity=32'h06000000.
  - Load v=-5, then Kick -> Velocity=32'h03000000.
  - Load v=32'h7E000000, then Kick -> Velocity=32'h7FFFFFFF.
- Ticks on three consecutive cycles from IDLE -> two steps commit (StepDone 6 and 13 cycles after the first Tick), Overrun=1 and stays set until reset.
- Reset_n pulsed low during MOVE -> outputs return immediately to INIT_POS/INIT_VEL, no StepDone, and the next Tick uses DV_HIGH.
